// File: rtl/uart_tx_engine.sv
// UART transmitter: one-hot control FSM, LSB-first shift datapath and baud divider,
// with a single holding register so the next byte can be queued while a frame shifts out.
module uart_tx_engine #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic                 SERIAL_OUT,
    output logic                 BUSY,
    output logic                 TX_DONE
);

    localparam bit HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);
    localparam bit ODD_PARITY = (PARITY_MODE == 2);
    localparam int BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam int BIT_W      = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_tx_engine: DATA_BITS must be 5..9");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_engine: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_engine: CLKS_PER_BIT must be >= 2");
    end
    if ((PARITY_MODE < 0) || (PARITY_MODE > 3)) begin : g_bad_parity
        $error("uart_tx_engine: PARITY_MODE must be 0..3");
    end

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_BITS-1:0]  r_hold_data;
    logic                  r_hold_full;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_shift_next;
    logic                  r_parity;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_serial;
    logic                  w_serial_next;
    logic                  w_bit_end;
    logic                  w_accept;
    logic                  w_load;

    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_accept  = TX_VALID && !r_hold_full;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_hold_full) begin
                    w_state_next = S_START;
                    w_load       = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit == DATA_LAST)) begin
                    w_state_next = HAS_PARITY ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // A queued byte chains straight into the next start bit.
                if (w_bit_end && (r_bit == STOP_LAST)) begin
                    if (r_hold_full) begin
                        w_state_next = S_START;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_shift_next = r_shift;
        if (w_load) begin
            w_shift_next = r_hold_data;
        end else if ((r_state == S_DATA) && w_bit_end) begin
            w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
        end

        // The line is registered, so it is driven from the state being entered.
        unique case (w_state_next)
            S_START:  w_serial_next = 1'b0;
            S_DATA:   w_serial_next = w_shift_next[0];
            S_PARITY: w_serial_next = r_parity;
            default:  w_serial_next = 1'b1;
        endcase

        BUSY    = (r_state != S_IDLE);
        TX_DONE = (r_state == S_STOP) && w_bit_end && (r_bit == STOP_LAST);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_baud      <= '0;
            r_bit       <= '0;
            r_serial    <= 1'b1;
        end else begin
            if (w_accept) begin
                r_hold_data <= DATA_IN;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            r_shift  <= w_shift_next;
            r_serial <= w_serial_next;

            if (w_load) begin
                r_parity <= (^r_hold_data) ^ ODD_PARITY;
            end

            if ((r_state == S_IDLE) || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            if (w_state_next != r_state) begin
                r_bit <= '0;
            end else if (w_bit_end && ((r_state == S_DATA) || (r_state == S_STOP))) begin
                r_bit <= r_bit + 1'b1;
            end
        end
    end

    assign TX_READY   = ~r_hold_full;
    assign SERIAL_OUT = r_serial;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Four transmitter configurations driven side by side; a per-lane cycle model queues
// each accepted frame and checks line, ready, busy and done on every falling edge.
module tb_uart_tx_engine;

    localparam int NLANE = 4;
    localparam int CPB   = 4;

    function automatic int lane_db(input int i);
        return (i == 3) ? 5 : 8;
    endfunction
    function automatic int lane_pm(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 0);
    endfunction
    function automatic int lane_sb(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    typedef struct {
        logic [15:0] bits;
        int          acc;
        int          start;
    } frame_t;

    logic       CLOCK;
    logic       RESET;
    logic [8:0] din   [NLANE];
    logic       valid [NLANE];
    logic       rdy   [NLANE];
    logic       ser   [NLANE];
    logic       busy  [NLANE];
    logic       done  [NLANE];
    int         done_seen [NLANE];
    int         cyc;
    int         n_checks;
    int         n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] make_frame(input logic [8:0] d, input int db,
                                               input int pm);
        logic [15:0] f;
        logic        p;
        int          k;
        f    = '1;
        p    = 1'b0;
        f[0] = 1'b0;
        k    = 1;
        for (int i = 0; i < db; i++) begin
            f[k] = d[i];
            p    = p ^ d[i];
            k++;
        end
        if (pm == 1) f[k] = p;
        else if (pm == 2) f[k] = ~p;
        return f;
    endfunction

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge CLOCK);
            cyc++;
        end
    end

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        localparam int DB  = lane_db(g);
        localparam int PM  = lane_pm(g);
        localparam int SB  = lane_sb(g);
        localparam int LEN = (1 + DB + ((PM == 1 || PM == 2) ? 1 : 0) + SB) * CPB;

        frame_t q[$];
        int     last_end;

        uart_tx_engine #(
            .DATA_BITS   (DB),
            .PARITY_MODE (PM),
            .STOP_BITS   (SB),
            .CLKS_PER_BIT(CPB)
        ) u_dut (
            .CLOCK     (CLOCK),
            .RESET     (RESET),
            .DATA_IN   (din[g][DB-1:0]),
            .TX_VALID  (valid[g]),
            .TX_READY  (rdy[g]),
            .SERIAL_OUT(ser[g]),
            .BUSY      (busy[g]),
            .TX_DONE   (done[g])
        );

        initial begin : mon
            int     e;
            int     n;
            int     s;
            logic   exp_line;
            logic   exp_busy;
            logic   exp_done;
            logic   hold;
            last_end     = 0;
            done_seen[g] = 0;
            forever begin
                @(negedge CLOCK);
                if (done[g]) done_seen[g]++;
                if (!RESET) begin
                    q.delete();
                    last_end = 0;
                    chk($sformatf("L%0d rst_line", g), 32'(ser[g]), 32'd1);
                    chk($sformatf("L%0d rst_ready", g), 32'(rdy[g]), 32'd1);
                    chk($sformatf("L%0d rst_busy", g), 32'(busy[g]), 32'd0);
                    chk($sformatf("L%0d rst_done", g), 32'(done[g]), 32'd0);
                end else begin
                    e        = cyc;
                    exp_line = 1'b1;
                    exp_busy = 1'b0;
                    exp_done = 1'b0;
                    hold     = 1'b0;
                    if ((q.size() > 0) && (q[0].start <= e)) begin
                        exp_line = q[0].bits[(e - q[0].start) / CPB];
                        exp_busy = 1'b1;
                        exp_done = (e == q[0].start + LEN - 1);
                    end
                    foreach (q[i]) begin
                        if ((q[i].acc <= e) && (q[i].start > e)) hold = 1'b1;
                    end
                    chk($sformatf("L%0d line", g), 32'(ser[g]), 32'(exp_line));
                    chk($sformatf("L%0d ready", g), 32'(rdy[g]), 32'(!hold));
                    chk($sformatf("L%0d busy", g), 32'(busy[g]), 32'(exp_busy));
                    chk($sformatf("L%0d done", g), 32'(done[g]), 32'(exp_done));
                    if (exp_done) void'(q.pop_front());
                    if (valid[g] && !hold) begin
                        n = e + 1;
                        s = (n + 1 > last_end) ? n + 1 : last_end;
                        q.push_back('{bits: make_frame(din[g], DB, PM), acc: n, start: s});
                        last_end = s + LEN;
                    end
                end
            end
        end
    end

    // Called at posedge+1; the byte is accepted on the following rising edge.
    task automatic send(input int l, input logic [8:0] d);
        int n;
        n = 0;
        while (!rdy[l] && (n < 200)) begin
            @(posedge CLOCK);
            #1;
            n++;
        end
        if (!rdy[l]) begin
            chk($sformatf("L%0d ready_timeout", l), 32'(rdy[l]), 32'd1);
            return;
        end
        din[l]   = d;
        valid[l] = 1'b1;
        @(posedge CLOCK);
        #1;
        valid[l] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RESET    = 1'b0;
        for (int i = 0; i < NLANE; i++) begin
            valid[i] = 1'b1;
            din[i]   = 9'h0AA;
        end
        repeat (3) @(posedge CLOCK);
        #1;
        for (int i = 0; i < NLANE; i++) valid[i] = 1'b0;
        RESET = 1'b1;
        repeat (4) @(posedge CLOCK);
        #1;

        send(0, 9'h0A5);
        repeat (50) @(posedge CLOCK);
        #1;

        send(0, 9'h03C);
        send(0, 9'h0C3);
        repeat (100) @(posedge CLOCK);
        #1;

        send(0, 9'h007);
        send(1, 9'h007);
        send(3, 9'h01F);
        send(2, 9'h007);
        // Next byte lands on the same edge the 40-cycle frame's stop bit ends.
        repeat (40) @(posedge CLOCK);
        #1;
        send(2, 9'h05A);
        repeat (80) @(posedge CLOCK);
        #1;

        send(0, 9'h000);
        repeat (18) @(posedge CLOCK);
        #2;
        RESET = 1'b0;
        #1;
        chk("L0 abort_line", 32'(ser[0]), 32'd1);
        chk("L0 abort_done", 32'(done[0]), 32'd0);
        chk("L0 abort_busy", 32'(busy[0]), 32'd0);
        repeat (2) @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        repeat (2) @(posedge CLOCK);
        #1;

        send(0, 9'h055);
        repeat (60) @(posedge CLOCK);
        #1;

        chk("L0 done_count", 32'(done_seen[0]), 32'd5);
        chk("L1 done_count", 32'(done_seen[1]), 32'd1);
        chk("L2 done_count", 32'(done_seen[2]), 32'd2);
        chk("L3 done_count", 32'(done_seen[3]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
